// File: rtl/telemetry_pkg.sv
// Shared definitions for the telemetry framer: FSM state encoding and default
// frame layout constants.
package telemetry_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC0 = 3'd1,
        ST_SYNC1 = 3'd2,
        ST_LEN   = 3'd3,
        ST_ADDR  = 3'd4,
        ST_DATA  = 3'd5,
        ST_CSUM  = 3'd6
    } state_e;

    localparam logic [7:0]  DEF_SYNC_A       = 8'hA5;
    localparam logic [7:0]  DEF_SYNC_B       = 8'h5A;
    localparam logic [7:0]  DEF_FIRST_ADDR   = 8'd1;
    localparam logic [7:0]  DEF_LAST_ADDR    = 8'd25;
    localparam int unsigned DEF_FRAME_PERIOD = 100000;

    // Payload length byte for an inclusive register address range.
    function automatic logic [7:0] frame_len(input logic [7:0] first, input logic [7:0] last);
        return last - first + 8'd1;
    endfunction

endpackage

// File: rtl/telemetry_framer_timer.sv
// Free-running frame period timer. Counts 0..FRAME_PERIOD-1 and flags the
// last count; a period of 0 parks the counter at 0 and never wraps.
module frame_period_timer
    import telemetry_pkg::*;
#(
    parameter int unsigned FRAME_PERIOD = DEF_FRAME_PERIOD
) (
    input  logic clk,
    input  logic rst,
    output logic wrap_o
);
    localparam int          PW  = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
    localparam bit          EN  = (FRAME_PERIOD != 0);
    localparam logic [PW-1:0] TOP = EN ? PW'(FRAME_PERIOD - 1) : '0;

    logic [PW-1:0] cnt_q, cnt_d;

    // Next count: roll over at the terminal value, hold at 0 when disabled.
    always_comb begin
        cnt_d = cnt_q + PW'(1);
        if (!EN || (cnt_q == TOP)) begin
            cnt_d = '0;
        end
    end

    // Period counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wrap_o = EN && (cnt_q == TOP);

endmodule

// File: rtl/telemetry_framer.sv
// Sweeps the sensor register file one byte address at a time and emits a
// framed packet (sync, length, payload, checksum) over a byte valid/ready link.
//
// state | meaning
// IDLE  | waiting for a trigger, link idle, reg_addr parked at 0
// SYNC0 | offering first sync byte
// SYNC1 | offering second sync byte
// LEN   | offering payload length, checksum seeded with it
// ADDR  | one-cycle register address phase, link idle
// DATA  | offering the byte captured at the end of ADDR
// CSUM  | offering the running checksum
module telemetry_framer
    import telemetry_pkg::*;
#(
    parameter logic [7:0]  FIRST_ADDR   = DEF_FIRST_ADDR,
    parameter logic [7:0]  LAST_ADDR    = DEF_LAST_ADDR,
    parameter logic [7:0]  SYNC_A       = DEF_SYNC_A,
    parameter logic [7:0]  SYNC_B       = DEF_SYNC_B,
    parameter int unsigned FRAME_PERIOD = DEF_FRAME_PERIOD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_req,
    output logic [7:0] reg_addr,
    input  logic [7:0] reg_data,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_dropped
);
    localparam logic [7:0] LEN = frame_len(FIRST_ADDR, LAST_ADDR);

    state_e     state_q, state_d;
    logic [7:0] addr_cnt_q, addr_cnt_d;
    logic [7:0] csum_q, csum_d;
    logic [7:0] reg_addr_q, reg_addr_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_valid_q, tx_valid_d;
    logic       busy_q, busy_d;
    logic       frame_done_q, frame_done_d;
    logic       frame_dropped_q, frame_dropped_d;

    logic timer_wrap;
    logic trigger;
    logic xfer;

    frame_period_timer #(
        .FRAME_PERIOD(FRAME_PERIOD)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .wrap_o(timer_wrap)
    );

    // A request and a timer wrap in the same cycle are a single trigger.
    assign trigger = frame_req | timer_wrap;
    assign xfer    = tx_valid_q & tx_ready;

    // Next-state and next-output logic; every output is computed one cycle
    // ahead so that it leaves the block straight from a flop.
    always_comb begin
        state_d         = state_q;
        addr_cnt_d      = addr_cnt_q;
        csum_d          = csum_q;
        reg_addr_d      = reg_addr_q;
        tx_data_d       = tx_data_q;
        tx_valid_d      = tx_valid_q;
        frame_done_d    = 1'b0;
        frame_dropped_d = trigger && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                tx_valid_d = 1'b0;
                reg_addr_d = '0;
                if (trigger) begin
                    state_d    = ST_SYNC0;
                    addr_cnt_d = FIRST_ADDR;
                    tx_valid_d = 1'b1;
                    tx_data_d  = SYNC_A;
                end
            end
            ST_SYNC0: begin
                if (xfer) begin
                    state_d   = ST_SYNC1;
                    tx_data_d = SYNC_B;
                end
            end
            ST_SYNC1: begin
                if (xfer) begin
                    state_d   = ST_LEN;
                    tx_data_d = LEN;
                    csum_d    = LEN;
                end
            end
            ST_LEN: begin
                if (xfer) begin
                    state_d    = ST_ADDR;
                    tx_valid_d = 1'b0;
                    reg_addr_d = addr_cnt_q;
                end
            end
            ST_ADDR: begin
                // Capture once; the byte is not re-sampled while stalled.
                state_d    = ST_DATA;
                tx_valid_d = 1'b1;
                tx_data_d  = reg_data;
                csum_d     = csum_q + reg_data;
            end
            ST_DATA: begin
                if (xfer) begin
                    if (addr_cnt_q == LAST_ADDR) begin
                        state_d   = ST_CSUM;
                        tx_data_d = csum_q;
                    end else begin
                        state_d    = ST_ADDR;
                        tx_valid_d = 1'b0;
                        addr_cnt_d = addr_cnt_q + 8'd1;
                        reg_addr_d = addr_cnt_q + 8'd1;
                    end
                end
            end
            ST_CSUM: begin
                if (xfer) begin
                    state_d      = ST_IDLE;
                    tx_valid_d   = 1'b0;
                    reg_addr_d   = '0;
                    frame_done_d = 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                tx_valid_d = 1'b0;
                reg_addr_d = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, counters and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            addr_cnt_q      <= '0;
            csum_q          <= '0;
            reg_addr_q      <= '0;
            tx_data_q       <= '0;
            tx_valid_q      <= 1'b0;
            busy_q          <= 1'b0;
            frame_done_q    <= 1'b0;
            frame_dropped_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_cnt_q      <= addr_cnt_d;
            csum_q          <= csum_d;
            reg_addr_q      <= reg_addr_d;
            tx_data_q       <= tx_data_d;
            tx_valid_q      <= tx_valid_d;
            busy_q          <= busy_d;
            frame_done_q    <= frame_done_d;
            frame_dropped_q <= frame_dropped_d;
        end
    end

    assign reg_addr      = reg_addr_q;
    assign tx_data       = tx_data_q;
    assign tx_valid      = tx_valid_q;
    assign busy          = busy_q;
    assign frame_done    = frame_done_q;
    assign frame_dropped = frame_dropped_q;

endmodule

// File: tb/tb_telemetry_framer.sv
`timescale 1ns/1ps
module tb_telemetry_framer;

    localparam logic [7:0] FIRST = 8'd1;
    localparam logic [7:0] LAST  = 8'd25;
    localparam logic [7:0] SA    = 8'hA5;
    localparam logic [7:0] SB    = 8'h5A;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0;

    // DUT A: timer disabled, used for request-driven scenarios.
    logic       req_a = 1'b0, ready_a = 1'b1;
    logic [7:0] reg_addr_a, reg_data_a, tx_data_a;
    logic       tx_valid_a, busy_a, frame_done_a, frame_dropped_a;
    logic [7:0] mem_a [256];

    // DUT B: 100-clock automatic trigger.
    logic       req_b = 1'b0, ready_b = 1'b1;
    logic [7:0] reg_addr_b, reg_data_b, tx_data_b;
    logic       tx_valid_b, busy_b, frame_done_b, frame_dropped_b;
    logic [7:0] mem_b [256];

    assign reg_data_a = mem_a[reg_addr_a];
    assign reg_data_b = mem_b[reg_addr_b];

    telemetry_framer #(.FRAME_PERIOD(0)) dut_a (
        .clk(clk), .rst(rst), .frame_req(req_a),
        .reg_addr(reg_addr_a), .reg_data(reg_data_a),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(ready_a),
        .busy(busy_a), .frame_done(frame_done_a), .frame_dropped(frame_dropped_a)
    );

    telemetry_framer #(.FRAME_PERIOD(100)) dut_b (
        .clk(clk), .rst(rst), .frame_req(req_b),
        .reg_addr(reg_addr_b), .reg_data(reg_data_b),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(ready_b),
        .busy(busy_b), .frame_done(frame_done_b), .frame_dropped(frame_dropped_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q [$];
    logic [7:0] got_a [$];
    int first_v, done_c, drop_c, ndrop, stall_err;
    bit mutated;

    // Reference frame: sync pair, length, register bytes in address order,
    // then the mod-256 sum of length and payload.
    function automatic void model_frame(input logic [7:0] m [256]);
        int sum;
        int len;
        len = int'(LAST) - int'(FIRST) + 1;
        exp_q.delete();
        exp_q.push_back(SA);
        exp_q.push_back(SB);
        exp_q.push_back(8'(len));
        sum = len;
        for (int a = int'(FIRST); a <= int'(LAST); a++) begin
            exp_q.push_back(m[a]);
            sum = sum + int'(m[a]);
        end
        exp_q.push_back(8'(sum % 256));
    endfunction

    task automatic start_frame(input bit immediate);
        if (!immediate) @(negedge clk);
        req_a = 1'b1;
        @(posedge clk); #1;
        req_a = 1'b0;
    endtask

    // Drives DUT A for one frame starting at its SYNC0 cycle (cycle 0) and
    // records accepted bytes, event cycles and stall-stability violations.
    task automatic run_frame(input int max_cyc, input bit rnd, input bit stalls, input int req_cyc);
        int  acc;
        int  force_low;
        bit  prev_stall;
        logic [7:0] prev_d;
        acc = 0; force_low = 0; prev_stall = 0; prev_d = '0;
        got_a.delete();
        first_v = -1; done_c = -1; drop_c = -1; ndrop = 0; stall_err = 0; mutated = 0;
        for (int n = 0; n < max_cyc; n++) begin
            @(negedge clk);
            if (prev_stall && (tx_valid_a !== 1'b1 || tx_data_a !== prev_d)) stall_err++;
            prev_stall = tx_valid_a && !ready_a;
            prev_d     = tx_data_a;
            if (tx_valid_a && first_v < 0) first_v = n;
            if (frame_dropped_a) begin
                ndrop++;
                if (drop_c < 0) drop_c = n;
            end
            if (frame_done_a) begin
                done_c = n;
                break;
            end
            if (stalls && tx_valid_a && acc == 9 && !mutated) begin
                mem_a[int'(FIRST) + 6] = ~mem_a[int'(FIRST) + 6];
                mutated = 1;
            end
            if (tx_valid_a && ready_a) begin
                got_a.push_back(tx_data_a);
                acc++;
                if (stalls && (acc == 1 || acc == 9)) force_low = 10;
            end
            @(posedge clk); #1;
            req_a = ((n + 1) == req_cyc);
            if (force_low > 0) begin
                ready_a = 1'b0;
                force_low--;
            end else if (rnd) begin
                ready_a = 1'($urandom_range(0, 1));
            end else begin
                ready_a = 1'b1;
            end
        end
        req_a   = 1'b0;
        ready_a = 1'b1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        n_checks++; if (reg_addr_a !== 8'h00) begin n_fail++; $display("FAIL reset_reg_addr got %h want 00", reg_addr_a); end
        n_checks++; if (tx_data_a !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data got %h want 00", tx_data_a); end
        n_checks++; if ({tx_valid_a, busy_a, frame_done_a, frame_dropped_a} !== 4'b0) begin
            n_fail++; $display("FAIL reset_flags got %b want 0000", {tx_valid_a, busy_a, frame_done_a, frame_dropped_a}); end
        n_checks++; if ({reg_addr_b, tx_data_b, tx_valid_b, busy_b, frame_done_b, frame_dropped_b} !== 20'b0) begin
            n_fail++; $display("FAIL reset_dut_b got %h want 0", {reg_addr_b, tx_data_b, tx_valid_b, busy_b, frame_done_b, frame_dropped_b}); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 256; i++) mem_a[i] = 8'(i);
        model_frame(mem_a);
        ready_a = 1'b1;
        start_frame(0);
        run_frame(200, 0, 0, -1);
        n_checks++; if (got_a.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_count got %0d want %0d", got_a.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= got_a.size() || got_a[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL basic_byte[%0d] got %h want %h", i, (i < got_a.size()) ? got_a[i] : 8'hxx, exp_q[i]); end
        end
        n_checks++; if (got_a.size() == 0 || got_a[got_a.size()-1] !== 8'h5E) begin
            n_fail++; $display("FAIL basic_csum got %h want 5e", (got_a.size() > 0) ? got_a[got_a.size()-1] : 8'hxx); end
        n_checks++; if (first_v != 0) begin n_fail++; $display("FAIL basic_first_valid got %0d want 0", first_v); end
        n_checks++; if (done_c != 54) begin n_fail++; $display("FAIL basic_done_cycle got %0d want 54", done_c); end
        n_checks++; if (ndrop != 0) begin n_fail++; $display("FAIL basic_drops got %0d want 0", ndrop); end
        @(negedge clk);
        n_checks++; if (frame_done_a !== 1'b0) begin n_fail++; $display("FAIL basic_done_width got %b want 0", frame_done_a); end
    endtask

    task automatic test_zeros();
        for (int i = 0; i < 256; i++) mem_a[i] = 8'h00;
        model_frame(mem_a);
        start_frame(0);
        run_frame(200, 0, 0, -1);
        n_checks++; if (got_a.size() != exp_q.size()) begin n_fail++; $display("FAIL zeros_count got %0d want %0d", got_a.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= got_a.size() || got_a[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL zeros_byte[%0d] got %h want %h", i, (i < got_a.size()) ? got_a[i] : 8'hxx, exp_q[i]); end
        end
        n_checks++; if (got_a.size() == 0 || got_a[got_a.size()-1] !== 8'h19) begin
            n_fail++; $display("FAIL zeros_csum got %h want 19", (got_a.size() > 0) ? got_a[got_a.size()-1] : 8'hxx); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 256; i++) mem_a[i] = 8'($urandom_range(0, 255));
        model_frame(mem_a);
        start_frame(0);
        run_frame(2000, 1, 1, -1);
        n_checks++; if (done_c < 0) begin n_fail++; $display("FAIL stall_timeout got no frame_done want done within 2000"); end
        n_checks++; if (got_a.size() != exp_q.size()) begin n_fail++; $display("FAIL stall_count got %0d want %0d", got_a.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= got_a.size() || got_a[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL stall_byte[%0d] got %h want %h", i, (i < got_a.size()) ? got_a[i] : 8'hxx, exp_q[i]); end
        end
        n_checks++; if (stall_err != 0) begin n_fail++; $display("FAIL stall_hold got %0d unstable cycles want 0", stall_err); end
        n_checks++; if (!mutated) begin n_fail++; $display("FAIL stall_mutate got 0 want 1"); end
    endtask

    task automatic test_drop_back_to_back();
        for (int i = 0; i < 256; i++) mem_a[i] = 8'($urandom_range(0, 255));
        model_frame(mem_a);
        start_frame(0);
        run_frame(200, 0, 0, 20);
        n_checks++; if (ndrop != 1) begin n_fail++; $display("FAIL drop_count got %0d want 1", ndrop); end
        n_checks++; if (drop_c != 21) begin n_fail++; $display("FAIL drop_cycle got %0d want 21", drop_c); end
        n_checks++; if (done_c != 54) begin n_fail++; $display("FAIL drop_done_cycle got %0d want 54", done_c); end
        n_checks++; if (got_a.size() != exp_q.size()) begin n_fail++; $display("FAIL drop_bytes got %0d want %0d", got_a.size(), exp_q.size()); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL drop_no_second_frame got busy %b want 0", busy_a); end
        end
        start_frame(0);
        run_frame(200, 0, 0, -1);
        for (int i = 0; i < 256; i++) mem_a[i] = 8'($urandom_range(0, 255));
        model_frame(mem_a);
        start_frame(1);
        run_frame(200, 0, 0, -1);
        n_checks++; if (first_v != 0) begin n_fail++; $display("FAIL b2b_first_valid got %0d want 0", first_v); end
        n_checks++; if (done_c != 54) begin n_fail++; $display("FAIL b2b_done_cycle got %0d want 54", done_c); end
        n_checks++; if (got_a.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count got %0d want %0d", got_a.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= got_a.size() || got_a[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL b2b_byte[%0d] got %h want %h", i, (i < got_a.size()) ? got_a[i] : 8'hxx, exp_q[i]); end
        end
    endtask

    task automatic test_timer();
        int starts [$];
        logic [7:0] gotb [$];
        logic [7:0] exp4 [$];
        int drops, dones;
        bit prev_busy;
        drops = 0; dones = 0; prev_busy = 0;
        for (int i = 0; i < 256; i++) mem_b[i] = 8'(i);
        model_frame(mem_b);
        for (int f = 0; f < 4; f++) foreach (exp_q[i]) exp4.push_back(exp_q[i]);
        ready_b = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int n = 0; n < 460; n++) begin
            @(negedge clk);
            if (busy_b && !prev_busy) starts.push_back(n);
            prev_busy = busy_b;
            if (frame_dropped_b) drops++;
            if (frame_done_b) dones++;
            if (tx_valid_b && ready_b) gotb.push_back(tx_data_b);
            @(posedge clk); #1;
            req_b = ((n + 1) == 399);
        end
        req_b = 1'b0;
        n_checks++; if (starts.size() != 4) begin n_fail++; $display("FAIL timer_starts got %0d want 4", starts.size()); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= starts.size() || starts[i] != 100 * (i + 1)) begin
                n_fail++; $display("FAIL timer_start[%0d] got %0d want %0d", i, (i < starts.size()) ? starts[i] : -1, 100 * (i + 1)); end
        end
        n_checks++; if (drops != 0) begin n_fail++; $display("FAIL timer_drops got %0d want 0", drops); end
        n_checks++; if (dones != 4) begin n_fail++; $display("FAIL timer_dones got %0d want 4", dones); end
        n_checks++; if (gotb.size() != exp4.size()) begin n_fail++; $display("FAIL timer_bytes got %0d want %0d", gotb.size(), exp4.size()); end
        for (int i = 0; i < exp4.size(); i++) begin
            n_checks++;
            if (i >= gotb.size() || gotb[i] !== exp4[i]) begin
                n_fail++; $display("FAIL timer_byte[%0d] got %h want %h", i, (i < gotb.size()) ? gotb[i] : 8'hxx, exp4[i]); end
        end
    endtask

    task automatic test_midreset();
        bit found;
        found = 0;
        for (int i = 0; i < 256; i++) mem_a[i] = 8'(i);
        model_frame(mem_a);
        start_frame(0);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (reg_addr_a == 8'd12) begin
                found = 1;
                break;
            end
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL midrst_reach got no addr 12 want addr 12 within 200"); end
        rst = 1'b1;
        #1;
        n_checks++; if ({reg_addr_a, tx_data_a} !== 16'h0000) begin
            n_fail++; $display("FAIL midrst_data got %h want 0000", {reg_addr_a, tx_data_a}); end
        n_checks++; if ({tx_valid_a, busy_a, frame_done_a, frame_dropped_a} !== 4'b0) begin
            n_fail++; $display("FAIL midrst_flags got %b want 0000", {tx_valid_a, busy_a, frame_done_a, frame_dropped_a}); end
        @(posedge clk); #1;
        rst = 1'b0;
        start_frame(0);
        run_frame(200, 0, 0, -1);
        n_checks++; if (done_c != 54) begin n_fail++; $display("FAIL midrst_done_cycle got %0d want 54", done_c); end
        n_checks++; if (got_a.size() != exp_q.size()) begin n_fail++; $display("FAIL midrst_count got %0d want %0d", got_a.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= got_a.size() || got_a[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL midrst_byte[%0d] got %h want %h", i, (i < got_a.size()) ? got_a[i] : 8'hxx, exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zeros();
        test_stall();
        test_drop_back_to_back();
        test_timer();
        test_midreset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/telemetry_framer.md
Name: telemetry_framer

Overview:
Downstream consumer of the sensor register file. It sweeps the register file's byte-address port, reads one byte per address, and packs the bytes into a framed telemetry packet. The packet carries sync, length, payload and checksum. Output is byte-wide with a valid/ready handshake, feeding the UART transmitter.

Parameters:
FIRST_ADDR, 8'd1, first register address read per frame
LAST_ADDR, 8'd25, last register address read per frame (LAST_ADDR >= FIRST_ADDR)
SYNC_A, 8'hA5, first sync byte
SYNC_B, 8'h5A, second sync byte
FRAME_PERIOD, 100000, clocks between automatic frame triggers; 0 disables the timer

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
frame_req  input  1  one-cycle pulse requesting a frame
reg_addr  output  8  byte address driven to the sensor register file
reg_data  input  8  byte returned by the register file (combinational from reg_addr)
tx_data  output  8  frame byte to UART
tx_valid  output  1  tx_data is valid
tx_ready  input  1  UART accepts byte this cycle
busy  output  1  frame in progress (state != IDLE)
frame_done  output  1  one-cycle pulse when the checksum byte is accepted
frame_dropped  output  1  one-cycle pulse when a trigger arrives while busy

Behaviour:
- Reset (async, immediate) drives the following to 0: reg_addr, tx_data, tx_valid, busy, frame_done, frame_dropped, period counter, checksum. State goes to IDLE. A reset mid-frame aborts the frame; there is no resumption.
- Trigger = frame_req OR timer wrap. Simultaneous frame_req and wrap count as one trigger.
- Timer: counts 0..FRAME_PERIOD-1 continuously, including while busy. Wrap is asserted on the cycle the count equals FRAME_PERIOD-1. With FRAME_PERIOD=0 the counter stays at 0 and never wraps.
- Trigger while not IDLE: ignored; frame_dropped pulses high for that cycle.
- Transfer occurs when tx_valid && tx_ready on a rising edge. tx_data is held stable while tx_valid=1 and tx_ready=0. tx_valid never deasserts before a transfer.
- Frame format, in order: SYNC_A, SYNC_B, LEN, payload[LEN], CSUM.
  - LEN = LAST_ADDR-FIRST_ADDR+1 (default 25 = 8'h19).
  - CSUM = 8-bit sum mod 256 of LEN and all payload bytes; sync bytes are excluded.
- States:
  - IDLE: tx_valid=0, reg_addr=0. On trigger, load addr_cnt=FIRST_ADDR and go to SYNC0.
  - SYNC0: tx_valid=1, tx_data=SYNC_A. On transfer go to SYNC1.
  - SYNC1: tx_data=SYNC_B. On transfer go to LEN.
  - LEN: tx_data=LEN. Checksum loads LEN. On transfer go to ADDR.
  - ADDR: one cycle, tx_valid=0, reg_addr=addr_cnt. Go to DATA.
  - DATA: on entry, tx_data is captured from reg_data (sampled at the end of the ADDR cycle) and checksum += captured byte. tx_valid=1 until transfer.
    - On transfer with addr_cnt==LAST_ADDR, go to CSUM.
    - Otherwise addr_cnt++ and go to ADDR.
  - CSUM: tx_data=checksum. On transfer, frame_done=1 for one cycle, go to IDLE.
- The captured byte is not re-sampled while waiting for tx_ready. Each payload byte reflects reg_data at exactly one clock.
- No inter-byte coherency guarantee: multi-byte sensor values may straddle register updates.
- With tx_ready tied high, a default frame takes 3 + 2*25 + 1 = 54 clocks from the first SYNC0 cycle to the CSUM transfer.
- A new trigger is accepted on the cycle after frame_done (IDLE).
- All outputs are registered.

Decomposition:
- Shared package telemetry_pkg: state encoding (IDLE, SYNC0, SYNC1, LEN, ADDR, DATA, CSUM), default SYNC_A/SYNC_B constants, default address range.
- One sub-module, frame_period_timer: parameter FRAME_PERIOD; inputs clk/rst; output wrap pulse. The FSM, address counter and checksum stay in telemetry_framer.

Test Plan:
1. Reg model returns reg_data = reg_addr; tx_ready=1; frame_req pulse -> bytes A5 5A 19 01 02 ... 19 5E (checksum 0x5E); frame_done pulses once, 54 clocks after the first tx_valid.
2. Reg model returns 0 for all addresses -> payload of 25 zero bytes, CSUM=0x19.
3. tx_ready toggled randomly (and held low for 10 cycles during SYNC1 and during payload byte 7) -> tx_data stable while stalled; no bytes lost or duplicated; reg_data changed during the stall does not alter the held byte.
4. frame_req pulsed at the 20th clock of a frame -> frame_dropped pulse that cycle; only one frame output; frame_req the cycle after frame_done -> second frame starts.
5. FRAME_PERIOD=100, no frame_req -> SYNC0 begins the cycle after each wrap (every 100 clocks); frame_req coincident with a wrap -> exactly one frame, no frame_dropped.
6. rst asserted mid-payload (addr 12) -> all outputs 0 asynchronously; after release, the next frame_req yields a complete frame starting at A5 with the correct checksum.
